// File: rtl/fpadd_issue_ctrl_if.sv
// Request, adder-operand and CDB signals between the FP-add reservation stations, the shared adder and the CDB.
// Latency: none. The interface only carries wires.
// Backpressure: cdb_ready stalls the result drain. req_grant is the acceptance for each entry.
interface fpadd_issue_ctrl_if #(
    parameter int NUM_RS = 4,
    parameter int TAG_W  = 4
);
    logic [NUM_RS-1:0]       req_valid;
    logic [NUM_RS*31-1:0]    req_a;
    logic [NUM_RS*31-1:0]    req_b;
    logic [NUM_RS*TAG_W-1:0] req_tag;
    logic [NUM_RS-1:0]       req_grant;
    logic [30:0]             add_in1;
    logic [30:0]             add_in2;
    logic [30:0]             add_result;
    logic                    flush;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [30:0]             cdb_data;
    logic                    cdb_ready;
    logic                    busy;

    // Environment side: reservation stations, adder result and CDB arbiter.
    modport master (
        output req_valid, req_a, req_b, req_tag, add_result, flush, cdb_ready,
        input  req_grant, add_in1, add_in2, cdb_valid, cdb_tag, cdb_data, busy
    );

    // Issue controller side.
    modport slave (
        input  req_valid, req_a, req_b, req_tag, add_result, flush, cdb_ready,
        output req_grant, add_in1, add_in2, cdb_valid, cdb_tag, cdb_data, busy
    );
endinterface

// File: rtl/fpadd_issue_ctrl.sv
// Round-robin issue of ready FP-add RS entries onto one shared registered adder, with results buffered for the CDB.
// Latency: the grant is combinational. A result reaches cdb_* two cycles after issue at the earliest.
// Backpressure: issue is held off unless the result FIFO is certain to have a slot when the adder result lands.
module fpadd_issue_ctrl #(
    parameter int NUM_RS    = 4,
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    fpadd_issue_ctrl_if.slave bus
);
    localparam int RR_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    logic [RR_W-1:0]  rr_ptr;
    logic             inflight_v;
    logic [TAG_W-1:0] inflight_tag;

    logic [30:0]      fifo_data [OUT_DEPTH];
    logic [TAG_W-1:0] fifo_tag  [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             cdb_vld;
    logic             pop;
    logic             push;
    logic             can_issue;
    logic             issue;
    logic             grant_any;
    logic [RR_W-1:0]  grant_idx;
    logic [RR_W-1:0]  scan_idx;
    int               scan_sum;
    logic [CNT_W:0]   occupancy;
    logic [NUM_RS-1:0] grant_vec;
    logic [30:0]      mux_a;
    logic [30:0]      mux_b;
    logic [TAG_W-1:0] mux_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cdb_vld = (count != '0);
    assign pop     = cdb_vld & bus.cdb_ready;
    // A flushed op's result is discarded as it comes out of the adder.
    assign push    = inflight_v & ~bus.flush;

    // Count the in-flight op as already occupying a slot, so the adder result always has a place to land.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_v) - (CNT_W+1)'(pop);
    assign can_issue = ~rst & ~bus.flush & (occupancy < (CNT_W+1)'(OUT_DEPTH));
    assign issue     = can_issue & grant_any;

    // Find the first ready entry at or after the rr pointer. The scan runs backwards so the nearest entry wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = 0;
        scan_idx  = '0;
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            scan_sum = int'(rr_ptr) + k;
            if (scan_sum >= NUM_RS) begin
                scan_sum = scan_sum - NUM_RS;
            end
            scan_idx = RR_W'(scan_sum);
            if (bus.req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Build the one-hot grant, then steer the granted entry's operands and tag. Everything is zero with no grant.
    always_comb begin
        grant_vec = '0;
        mux_a     = '0;
        mux_b     = '0;
        mux_tag   = '0;
        if (issue) begin
            grant_vec[grant_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_RS; i++) begin
            if (grant_vec[i]) begin
                mux_a   = bus.req_a[31*i +: 31];
                mux_b   = bus.req_b[31*i +: 31];
                mux_tag = bus.req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    assign bus.req_grant = grant_vec;
    assign bus.add_in1   = mux_a;
    assign bus.add_in2   = mux_b;
    assign bus.cdb_valid = cdb_vld;
    assign bus.cdb_data  = cdb_vld ? fifo_data[rd_ptr] : '0;
    assign bus.cdb_tag   = cdb_vld ? fifo_tag[rd_ptr] : '0;
    assign bus.busy      = inflight_v | cdb_vld;

    // Advance the rr pointer past each granted entry, and track which tag is in the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            inflight_v   <= 1'b0;
            inflight_tag <= '0;
        end else begin
            inflight_v <= issue;
            if (issue) begin
                rr_ptr       <= (grant_idx == RR_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;
                inflight_tag <= mux_tag;
            end
        end
    end

    // Result FIFO control: wrap-around pointers plus an explicit count. A flush empties it.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Result FIFO storage. The outputs gate it with cdb_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_data[wr_ptr] <= bus.add_result;
            fifo_tag[wr_ptr]  <= inflight_tag;
        end
    end
endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Directed bench for fpadd_issue_ctrl, with a behavioural registered unsigned FP adder on the adder port.
// Latency: inputs are driven 1 time unit after posedge. Outputs are sampled on the following negedge.
// Backpressure: cdb_ready is driven directly by each step of the sequence.
module tb_fpadd_issue_ctrl;
    localparam int NUM_RS    = 4;
    localparam int TAG_W     = 4;
    localparam int OUT_DEPTH = 2;

    localparam logic [30:0] ONE      = 31'h3F800000;
    localparam logic [30:0] ONE_HALF = 31'h3FC00000;
    localparam logic [30:0] TWO      = 31'h40000000;
    localparam logic [30:0] TWO_HALF = 31'h40200000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] rr_tag [4];
    logic [31:0] rr_dat [4];
    logic [3:0]  exp_grant;

    fpadd_issue_ctrl_if #(.NUM_RS(NUM_RS), .TAG_W(TAG_W)) bus ();

    fpadd_issue_ctrl #(.NUM_RS(NUM_RS), .TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Unsigned-magnitude FP add with truncation. It is exact for the operands used here.
    function automatic logic [30:0] fp_add(input logic [30:0] x, input logic [30:0] y);
        logic [30:0] hi;
        logic [30:0] lo;
        logic [7:0]  shamt;
        logic [24:0] mh;
        logic [24:0] ml;
        logic [24:0] sum;
        if (y[30:23] > x[30:23]) begin
            hi = y;
            lo = x;
        end else begin
            hi = x;
            lo = y;
        end
        shamt = hi[30:23] - lo[30:23];
        mh    = {1'b0, hi[30:23] != 8'd0, hi[22:0]};
        ml    = {1'b0, lo[30:23] != 8'd0, lo[22:0]};
        ml    = (shamt > 8'd24) ? 25'd0 : (ml >> shamt);
        sum   = mh + ml;
        if (sum[24]) begin
            return {hi[30:23] + 8'd1, sum[23:1]};
        end
        return {hi[30:23], sum[22:0]};
    endfunction

    // The external adder: registered with one-cycle latency, and cleared by rst.
    always @(posedge clk) begin
        if (rst) begin
            bus.add_result <= '0;
        end else begin
            bus.add_result <= fp_add(bus.add_in1, bus.add_in2);
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic chk_cdb(input string lbl, input logic v, input logic [31:0] tag, input logic [31:0] dat);
        chk({lbl, " cdb_valid"}, 32'(bus.cdb_valid), 32'(v));
        if (v) begin
            chk({lbl, " cdb_tag"}, 32'(bus.cdb_tag), tag);
            chk({lbl, " cdb_data"}, 32'(bus.cdb_data), dat);
        end
    endtask

    task automatic set_entry(input int i, input logic [30:0] a, input logic [30:0] b, input logic [TAG_W-1:0] t);
        bus.req_a[31*i +: 31]        = a;
        bus.req_b[31*i +: 31]        = b;
        bus.req_tag[TAG_W*i +: TAG_W] = t;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;
        bus.cdb_ready = 1'b0;
        set_entry(0, ONE, ONE, 4'd3);
        set_entry(1, ONE_HALF, ONE, 4'd6);
        set_entry(2, ONE, ONE, 4'd7);
        set_entry(3, ONE_HALF, ONE, 4'd5);
        rr_tag = '{32'd3, 32'd6, 32'd7, 32'd5};
        rr_dat = '{32'(TWO), 32'(TWO_HALF), 32'(TWO), 32'(TWO_HALF)};

        // Reset state
        go(); go(); mid();
        chk("rst grant", 32'(bus.req_grant), 32'd0);
        chk("rst cdb_valid", 32'(bus.cdb_valid), 32'd0);
        chk("rst cdb_tag", 32'(bus.cdb_tag), 32'd0);
        chk("rst cdb_data", 32'(bus.cdb_data), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst add_in1", 32'(bus.add_in1), 32'd0);
        chk("rst add_in2", 32'(bus.add_in2), 32'd0);

        // Single op: 1.0 + 1.0 on entry 0 with tag 3
        go(); rst = 1'b0; bus.cdb_ready = 1'b1; bus.req_valid = 4'b0001; mid();
        chk("single grant", 32'(bus.req_grant), 32'b0001);
        chk("single add_in1", 32'(bus.add_in1), 32'(ONE));
        chk("single add_in2", 32'(bus.add_in2), 32'(ONE));
        chk_cdb("single T", 1'b0, 0, 0);
        go(); bus.req_valid = '0; mid();
        chk("single T+1 grant", 32'(bus.req_grant), 32'd0);
        chk("single T+1 busy", 32'(bus.busy), 32'd1);
        chk_cdb("single T+1", 1'b0, 0, 0);
        go(); mid();
        chk_cdb("single T+2", 1'b1, 32'd3, 32'(TWO));
        go(); mid();
        chk_cdb("single T+3", 1'b0, 0, 0);
        chk("single idle busy", 32'(bus.busy), 32'd0);

        // Data: 1.5 + 1.0 on entry 3 with tag 5. Only entry 3 is requesting, so rr wraps to 0
        go(); bus.req_valid = 4'b1000; mid();
        chk("data grant", 32'(bus.req_grant), 32'b1000);
        chk("data add_in1", 32'(bus.add_in1), 32'(ONE_HALF));
        go(); bus.req_valid = '0; mid();
        chk_cdb("data T+1", 1'b0, 0, 0);
        go(); mid();
        chk_cdb("data T+2", 1'b1, 32'd5, 32'(TWO_HALF));
        go(); mid();
        chk_cdb("data T+3", 1'b0, 0, 0);

        // Round robin: all four entries requesting for five cycles, CDB always ready
        for (int k = 0; k < 7; k++) begin
            go();
            bus.req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            mid();
            exp_grant = (k < 5) ? (4'b0001 << (k % 4)) : 4'b0000;
            chk($sformatf("rr%0d grant", k), 32'(bus.req_grant), 32'(exp_grant));
            if (k >= 2) begin
                chk_cdb($sformatf("rr%0d", k), 1'b1, rr_tag[(k-2)%4], rr_dat[(k-2)%4]);
            end else begin
                chk_cdb($sformatf("rr%0d", k), 1'b0, 0, 0);
            end
        end
        go(); mid();
        chk_cdb("rr drained", 1'b0, 0, 0);

        // Backpressure: entries 1 and 2 requesting, CDB stalled
        go(); bus.cdb_ready = 1'b0; bus.req_valid = 4'b0110; mid();
        chk("bp0 grant", 32'(bus.req_grant), 32'b0010);
        go(); mid();
        chk("bp1 grant", 32'(bus.req_grant), 32'b0100);
        go(); mid();
        chk("bp2 grant", 32'(bus.req_grant), 32'd0);
        chk_cdb("bp2", 1'b1, 32'd6, 32'(TWO_HALF));
        go(); mid();
        chk("bp3 grant", 32'(bus.req_grant), 32'd0);
        chk_cdb("bp3", 1'b1, 32'd6, 32'(TWO_HALF));
        go(); mid();
        chk("bp4 grant", 32'(bus.req_grant), 32'd0);
        chk("bp4 busy", 32'(bus.busy), 32'd1);
        go(); bus.cdb_ready = 1'b1; mid();
        chk("bp5 grant", 32'(bus.req_grant), 32'b0010);
        chk_cdb("bp5", 1'b1, 32'd6, 32'(TWO_HALF));
        go(); mid();
        chk("bp6 grant", 32'(bus.req_grant), 32'b0100);
        chk_cdb("bp6", 1'b1, 32'd7, 32'(TWO));
        go(); bus.req_valid = '0; mid();
        chk("bp7 grant", 32'(bus.req_grant), 32'd0);
        chk_cdb("bp7", 1'b1, 32'd6, 32'(TWO_HALF));
        go(); mid();
        chk_cdb("bp8", 1'b1, 32'd7, 32'(TWO));
        go(); mid();
        chk_cdb("bp9", 1'b0, 0, 0);
        chk("bp9 busy", 32'(bus.busy), 32'd0);

        // Flush: entry 3 is buffered and entry 0 is in flight when flush rises. rr is preserved at 1
        go(); bus.cdb_ready = 1'b0; bus.req_valid = 4'b1001; mid();
        chk("fl0 grant", 32'(bus.req_grant), 32'b1000);
        go(); mid();
        chk("fl1 grant", 32'(bus.req_grant), 32'b0001);
        go(); bus.flush = 1'b1; mid();
        chk("fl2 grant", 32'(bus.req_grant), 32'd0);
        chk_cdb("fl2", 1'b1, 32'd5, 32'(TWO_HALF));
        go(); bus.flush = 1'b0; bus.req_valid = '0; bus.cdb_ready = 1'b1; mid();
        chk_cdb("fl3", 1'b0, 0, 0);
        chk("fl3 busy", 32'(bus.busy), 32'd0);
        go(); mid();
        chk_cdb("fl4", 1'b0, 0, 0);
        go(); bus.req_valid = 4'b1111; mid();
        chk("fl5 grant", 32'(bus.req_grant), 32'b0010);
        go(); bus.req_valid = '0; mid();
        chk_cdb("fl6", 1'b0, 0, 0);
        go(); mid();
        chk_cdb("fl7", 1'b1, 32'd6, 32'(TWO_HALF));
        go(); mid();
        chk_cdb("fl8", 1'b0, 0, 0);

        // Reset mid-operation with one result buffered and one in flight. rr is at 3 before the reset
        go(); bus.cdb_ready = 1'b0; bus.req_valid = 4'b0100; mid();
        chk("rs0 grant", 32'(bus.req_grant), 32'b0100);
        go(); mid();
        chk("rs1 grant", 32'(bus.req_grant), 32'b0100);
        go(); rst = 1'b1; mid();
        chk("rs2 grant", 32'(bus.req_grant), 32'd0);
        go(); rst = 1'b0; bus.req_valid = '0; bus.cdb_ready = 1'b1; mid();
        chk("rs3 grant", 32'(bus.req_grant), 32'd0);
        chk("rs3 cdb_valid", 32'(bus.cdb_valid), 32'd0);
        chk("rs3 cdb_tag", 32'(bus.cdb_tag), 32'd0);
        chk("rs3 cdb_data", 32'(bus.cdb_data), 32'd0);
        chk("rs3 busy", 32'(bus.busy), 32'd0);
        chk("rs3 add_in1", 32'(bus.add_in1), 32'd0);
        chk("rs3 add_in2", 32'(bus.add_in2), 32'd0);
        go(); mid();
        chk_cdb("rs4", 1'b0, 0, 0);
        chk("rs4 busy", 32'(bus.busy), 32'd0);
        go(); bus.req_valid = 4'b1111; mid();
        chk("rs5 grant", 32'(bus.req_grant), 32'b0001);
        chk("rs5 add_in1", 32'(bus.add_in1), 32'(ONE));
        go(); bus.req_valid = '0; mid();
        chk_cdb("rs6", 1'b0, 0, 0);
        go(); mid();
        chk_cdb("rs7", 1'b1, 32'd3, 32'(TWO));
        go(); mid();
        chk_cdb("rs8", 1'b0, 0, 0);
        chk("rs8 busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
